// File: rtl/traffic_intersection_ctrl.sv
// traffic_intersection_ctrl
//   Phase sequencer for a main/side road intersection with a pedestrian
//   crossing. Main road rests on green; latched side-sensor and pedestrian
//   requests break the main phase once the minimum green has been served.
//   All-red clearance separates every pair of conflicting phases.
//
// Ports
//   clk            system clock, rising edge
//   reset          asynchronous, active-high; clears all state
//   side_req       side-road vehicle sensor (level or pulse)
//   ped_req        pedestrian button (any-width pulse)
//   main_r/y/g     main road lamps
//   side_r/y/g     side road lamps
//   walk           pedestrian walk lamp
//   phase          current state encoding
//
// State table
//   state    | meaning
//   MAIN_G   | main green, side red; holds until min green served and a request is pending
//   MAIN_Y   | main yellow
//   RED_A    | all-red clearance after main phase
//   SIDE_G   | side green
//   SIDE_Y   | side yellow
//   RED_B    | all-red clearance before main green / walk (reset state)
//   PED_WALK | walk lamp on, both roads red
module traffic_intersection_ctrl #(
  parameter int CNT_W      = 8,
  parameter int MAIN_MIN   = 10,
  parameter int SIDE_GREEN = 6,
  parameter int YELLOW     = 3,
  parameter int ALLRED     = 2,
  parameter int WALK       = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       side_req,
  input  logic       ped_req,
  output logic       main_r,
  output logic       main_y,
  output logic       main_g,
  output logic       side_r,
  output logic       side_y,
  output logic       side_g,
  output logic       walk,
  output logic [2:0] phase
);

  typedef enum logic [2:0] {
    MAIN_G   = 3'd0,
    MAIN_Y   = 3'd1,
    RED_A    = 3'd2,
    SIDE_G   = 3'd3,
    SIDE_Y   = 3'd4,
    RED_B    = 3'd5,
    PED_WALK = 3'd6
  } state_t;

  state_t           state;
  state_t           next_state;
  logic [CNT_W-1:0] timer;
  logic [CNT_W-1:0] timer_next;
  logic             timer_done;
  logic             entry;
  logic             side_pending;
  logic             ped_pending;

  // Timer load value on entry: duration minus one, so the state lasts
  // exactly its duration when it exits on the terminal count.
  function automatic logic [CNT_W-1:0] duration_m1(input state_t s);
    case (s)
      MAIN_G:   duration_m1 = CNT_W'(MAIN_MIN - 1);
      MAIN_Y:   duration_m1 = CNT_W'(YELLOW - 1);
      RED_A:    duration_m1 = CNT_W'(ALLRED - 1);
      SIDE_G:   duration_m1 = CNT_W'(SIDE_GREEN - 1);
      SIDE_Y:   duration_m1 = CNT_W'(YELLOW - 1);
      PED_WALK: duration_m1 = CNT_W'(WALK - 1);
      default:  duration_m1 = CNT_W'(ALLRED - 1);
    endcase
  endfunction

  always_comb begin
    next_state = state;
    timer_done = (timer == '0);
    case (state)
      MAIN_G:   if (timer_done && (side_pending || ped_pending)) next_state = MAIN_Y;
      MAIN_Y:   if (timer_done) next_state = RED_A;
      RED_A:    if (timer_done) next_state = side_pending ? SIDE_G : PED_WALK;
      SIDE_G:   if (timer_done) next_state = SIDE_Y;
      SIDE_Y:   if (timer_done) next_state = RED_B;
      RED_B:    if (timer_done) next_state = ped_pending ? PED_WALK : MAIN_G;
      PED_WALK: if (timer_done) next_state = RED_B;
      default:  next_state = RED_B;  // unused encoding recovers to clearance
    endcase

    entry = (next_state != state);
    if (entry)
      timer_next = duration_m1(next_state);
    else if (timer_done)
      timer_next = '0;
    else
      timer_next = timer - CNT_W'(1);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= RED_B;
      timer        <= CNT_W'(ALLRED - 1);
      side_pending <= 1'b0;
      ped_pending  <= 1'b0;
      main_r       <= 1'b1;
      main_y       <= 1'b0;
      main_g       <= 1'b0;
      side_r       <= 1'b1;
      side_y       <= 1'b0;
      side_g       <= 1'b0;
      walk         <= 1'b0;
    end else begin
      state <= next_state;
      timer <= timer_next;

      // Clear on entry wins over a same-edge set; requests are ignored while
      // the phase that would serve them is already running.
      if (entry && next_state == SIDE_G)
        side_pending <= 1'b0;
      else if (side_req && state != SIDE_G && state != SIDE_Y)
        side_pending <= 1'b1;

      if (entry && next_state == PED_WALK)
        ped_pending <= 1'b0;
      else if (ped_req && state != PED_WALK)
        ped_pending <= 1'b1;

      // Lamps decoded from next_state so they update on the same edge as state.
      main_g <= (next_state == MAIN_G);
      main_y <= (next_state == MAIN_Y);
      main_r <= !(next_state == MAIN_G || next_state == MAIN_Y);
      side_g <= (next_state == SIDE_G);
      side_y <= (next_state == SIDE_Y);
      side_r <= !(next_state == SIDE_G || next_state == SIDE_Y);
      walk   <= (next_state == PED_WALK);
    end
  end

  assign phase = state;

endmodule

// File: tb/tb_traffic_intersection_ctrl.sv
module tb_traffic_intersection_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic       side_req;
  logic       ped_req;
  logic       main_r, main_y, main_g;
  logic       side_r, side_y, side_g;
  logic       walk;
  logic [2:0] phase;
  logic [6:0] lamps;

  int checks   = 0;
  int failures = 0;

  traffic_intersection_ctrl dut (
    .clk      (clk),
    .reset    (reset),
    .side_req (side_req),
    .ped_req  (ped_req),
    .main_r   (main_r),
    .main_y   (main_y),
    .main_g   (main_g),
    .side_r   (side_r),
    .side_y   (side_y),
    .side_g   (side_g),
    .walk     (walk),
    .phase    (phase)
  );

  always #5 clk = ~clk;

  assign lamps = {main_r, main_y, main_g, side_r, side_y, side_g, walk};

  // Expected {main_r,main_y,main_g,side_r,side_y,side_g,walk} for each phase.
  function automatic logic [6:0] exp_lamps(input int ph);
    case (ph)
      0:       exp_lamps = 7'b0011000;
      1:       exp_lamps = 7'b0101000;
      3:       exp_lamps = 7'b1000010;
      4:       exp_lamps = 7'b1000100;
      6:       exp_lamps = 7'b1001001;
      default: exp_lamps = 7'b1001000;
    endcase
  endfunction

  // Leaves the bench at a falling edge with reset just released (sample 0).
  task automatic do_reset();
    reset    = 1'b1;
    side_req = 1'b0;
    ped_req  = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    @(posedge clk);
    #3;
    reset    = 1'b1;
    side_req = 1'b0;
    ped_req  = 1'b0;
    #1;
    checks++;
    if (phase !== 3'd5) begin
      failures++;
      $display("FAIL reset_phase got=%0d exp=5", phase);
    end
    checks++;
    if (lamps !== 7'b1001000) begin
      failures++;
      $display("FAIL reset_lamps got=%b exp=%b", lamps, 7'b1001000);
    end
    @(negedge clk);
    checks++;
    if (phase !== 3'd5) begin
      failures++;
      $display("FAIL reset_hold_phase got=%0d exp=5", phase);
    end
  endtask

  task automatic test_idle_hold();
    int ph  [2] = '{5, 0};
    int len [2] = '{2, 101};
    int s;
    s = 0;
    do_reset();
    for (int g = 0; g < 2; g++) begin
      for (int c = 0; c < len[g]; c++) begin
        checks++;
        if (phase !== 3'(ph[g])) begin
          failures++;
          $display("FAIL idle_phase sample=%0d got=%0d exp=%0d", s, phase, ph[g]);
        end
        checks++;
        if (lamps !== exp_lamps(ph[g])) begin
          failures++;
          $display("FAIL idle_lamps sample=%0d got=%b exp=%b", s, lamps, exp_lamps(ph[g]));
        end
        @(negedge clk);
        s++;
      end
    end
  endtask

  task automatic test_side();
    int ph  [8] = '{5, 0, 1, 2, 3, 4, 5, 0};
    int len [8] = '{2, 10, 3, 2, 6, 3, 2, 5};
    int s;
    s = 0;
    do_reset();
    for (int g = 0; g < 8; g++) begin
      for (int c = 0; c < len[g]; c++) begin
        checks++;
        if (phase !== 3'(ph[g])) begin
          failures++;
          $display("FAIL side_phase sample=%0d got=%0d exp=%0d", s, phase, ph[g]);
        end
        checks++;
        if (lamps !== exp_lamps(ph[g])) begin
          failures++;
          $display("FAIL side_lamps sample=%0d got=%b exp=%b", s, lamps, exp_lamps(ph[g]));
        end
        side_req = (s == 4);
        @(negedge clk);
        s++;
      end
    end
    side_req = 1'b0;
  endtask

  task automatic test_ped();
    int ph  [7] = '{5, 0, 1, 2, 6, 5, 0};
    int len [7] = '{2, 10, 3, 2, 4, 2, 5};
    int s;
    s = 0;
    do_reset();
    for (int g = 0; g < 7; g++) begin
      for (int c = 0; c < len[g]; c++) begin
        checks++;
        if (phase !== 3'(ph[g])) begin
          failures++;
          $display("FAIL ped_phase sample=%0d got=%0d exp=%0d", s, phase, ph[g]);
        end
        checks++;
        if (lamps !== exp_lamps(ph[g])) begin
          failures++;
          $display("FAIL ped_lamps sample=%0d got=%b exp=%b", s, lamps, exp_lamps(ph[g]));
        end
        // second press lands mid-walk and must be ignored
        ped_req = (s == 3) || (s == 18);
        @(negedge clk);
        s++;
      end
    end
    ped_req = 1'b0;
  endtask

  task automatic test_back_to_back();
    int ph  [10] = '{5, 0, 1, 2, 3, 4, 5, 6, 5, 0};
    int len [10] = '{2, 10, 3, 2, 6, 3, 2, 4, 2, 5};
    int s;
    s = 0;
    do_reset();
    for (int g = 0; g < 10; g++) begin
      for (int c = 0; c < len[g]; c++) begin
        checks++;
        if (phase !== 3'(ph[g])) begin
          failures++;
          $display("FAIL both_phase sample=%0d got=%0d exp=%0d", s, phase, ph[g]);
        end
        checks++;
        if (lamps !== exp_lamps(ph[g])) begin
          failures++;
          $display("FAIL both_lamps sample=%0d got=%b exp=%b", s, lamps, exp_lamps(ph[g]));
        end
        side_req = (s == 5);
        ped_req  = (s == 5);
        @(negedge clk);
        s++;
      end
    end
    side_req = 1'b0;
    ped_req  = 1'b0;
  endtask

  task automatic test_latency();
    int ph  [8] = '{5, 0, 1, 2, 3, 4, 5, 0};
    int len [8] = '{2, 42, 3, 2, 6, 3, 2, 3};
    int s;
    s = 0;
    do_reset();
    for (int g = 0; g < 8; g++) begin
      for (int c = 0; c < len[g]; c++) begin
        checks++;
        if (phase !== 3'(ph[g])) begin
          failures++;
          $display("FAIL latency_phase sample=%0d got=%0d exp=%0d", s, phase, ph[g]);
        end
        checks++;
        if (lamps !== exp_lamps(ph[g])) begin
          failures++;
          $display("FAIL latency_lamps sample=%0d got=%b exp=%b", s, lamps, exp_lamps(ph[g]));
        end
        side_req = (s == 42);
        @(negedge clk);
        s++;
      end
    end
    side_req = 1'b0;
  endtask

  task automatic test_reset_mid();
    int ph  [5] = '{5, 0, 1, 2, 3};
    int len [5] = '{2, 10, 3, 2, 2};
    int ph2 [2] = '{5, 0};
    int len2[2] = '{2, 15};
    int s;
    s = 0;
    do_reset();
    for (int g = 0; g < 5; g++) begin
      for (int c = 0; c < len[g]; c++) begin
        checks++;
        if (phase !== 3'(ph[g])) begin
          failures++;
          $display("FAIL midrst_phase sample=%0d got=%0d exp=%0d", s, phase, ph[g]);
        end
        side_req = (s == 3);
        // pedestrian press latched during side green, then discarded by reset
        ped_req  = (s == 18);
        @(negedge clk);
        s++;
      end
    end
    side_req = 1'b0;
    ped_req  = 1'b0;
    checks++;
    if (side_g !== 1'b1) begin
      failures++;
      $display("FAIL midrst_pre_side_g got=%b exp=1", side_g);
    end
    #2;
    reset = 1'b1;
    #1;
    checks++;
    if (side_g !== 1'b0) begin
      failures++;
      $display("FAIL midrst_side_g got=%b exp=0", side_g);
    end
    checks++;
    if (lamps !== 7'b1001000) begin
      failures++;
      $display("FAIL midrst_lamps got=%b exp=%b", lamps, 7'b1001000);
    end
    checks++;
    if (phase !== 3'd5) begin
      failures++;
      $display("FAIL midrst_phase_async got=%0d exp=5", phase);
    end
    @(negedge clk);
    reset = 1'b0;
    s = 0;
    for (int g = 0; g < 2; g++) begin
      for (int c = 0; c < len2[g]; c++) begin
        checks++;
        if (phase !== 3'(ph2[g])) begin
          failures++;
          $display("FAIL midrst_after_phase sample=%0d got=%0d exp=%0d", s, phase, ph2[g]);
        end
        checks++;
        if (lamps !== exp_lamps(ph2[g])) begin
          failures++;
          $display("FAIL midrst_after_lamps sample=%0d got=%b exp=%b", s, lamps, exp_lamps(ph2[g]));
        end
        @(negedge clk);
        s++;
      end
    end
  endtask

  initial begin
    reset    = 1'b1;
    side_req = 1'b0;
    ped_req  = 1'b0;
    test_reset();
    test_idle_hold();
    test_side();
    test_ped();
    test_back_to_back();
    test_latency();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/traffic_intersection_ctrl.md
Name: traffic_intersection_ctrl

Overview:
Phase sequencer for a two-road intersection, main road and side road, with a pedestrian crossing. It drives both roads' red/yellow/green lamps and a walk lamp. Main road rests on green. Latched side-sensor and pedestrian-button requests break the main phase once a minimum green time has been served. All-red clearance intervals are inserted between conflicting phases.

Parameters:
CNT_W, 8, phase timer width in bits
MAIN_MIN, 10, minimum main-green cycles (>=1, < 2^CNT_W)
SIDE_GREEN, 6, side-green cycles, fixed
YELLOW, 3, yellow cycles, both roads
ALLRED, 2, all-red clearance cycles
WALK, 4, pedestrian walk cycles

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-high; clears all state
side_req  in  1  side-road vehicle sensor, level or pulse
ped_req  in  1  pedestrian button, any-width pulse
main_r  out  1  main road red
main_y  out  1  main road yellow
main_g  out  1  main road green
side_r  out  1  side road red
side_y  out  1  side road yellow
side_g  out  1  side road green
walk  out  1  pedestrian walk lamp
phase  out  3  current state encoding, for debug and bench checks

Behaviour:
- Clock and reset: one clock domain; reset is asynchronous and active-high.
- State encodings: MAIN_G=0, MAIN_Y=1, RED_A=2, SIDE_G=3, SIDE_Y=4, RED_B=5, PED_WALK=6. Encoding 7 is unused and recovers to RED_B on the next edge.
- Outputs are registered and Moore; they change on the same edge as the state register.
  - main_g only in MAIN_G; main_y only in MAIN_Y; main_r in all other states.
  - side_g only in SIDE_G; side_y only in SIDE_Y; side_r in all other states.
  - walk only in PED_WALK.
- Reset value: state=RED_B with timer=ALLRED-1; main_r=side_r=1; all other lamps 0; phase=5; side_pending=ped_pending=0. The reset effect is immediate, not clock-gated.
- Timer:
  - On every state entry, load the timer with (that state's duration - 1); decrement each cycle; saturate at 0.
  - A state exits on the edge where timer==0 and its exit condition holds. A timed state therefore lasts exactly its duration in cycles.
- Request latches:
  - side_pending is set on any edge where side_req=1.
  - ped_pending is set on any edge where ped_req=1.
  - side_pending clears on entry to SIDE_G. Requests sampled while in SIDE_G or SIDE_Y are ignored.
  - ped_pending clears on entry to PED_WALK. Requests sampled while in PED_WALK are ignored.
  - Set and clear on the same edge: clear wins.
- Transitions:
  - MAIN_G -> MAIN_Y when timer==0 and (side_pending or ped_pending). With no request, main green holds indefinitely.
  - MAIN_Y -> RED_A after YELLOW cycles.
  - RED_A -> SIDE_G after ALLRED if side_pending; otherwise -> PED_WALK. Side road has priority over pedestrians.
  - SIDE_G -> SIDE_Y after SIDE_GREEN; SIDE_Y -> RED_B after YELLOW.
  - RED_B -> PED_WALK after ALLRED if ped_pending; otherwise -> MAIN_G.
  - PED_WALK -> RED_B after WALK.
- Request latency: a request arriving after MAIN_MIN has elapsed is latched on edge N; main_y asserts on edge N+1.
- Safety invariant:
  - Never two greens at once; never a green together with walk.
  - Every green-to-conflict change passes through yellow (vehicles) and an all-red state.
- A reset in any state forces the reset values immediately and discards pending requests.

Test Plan:
- Release reset, no requests: RED_B (all red) for 2 cycles -> main_g=1 from cycle 3; held for 100 further cycles with phase=0.
- side_req 1-cycle pulse at main-green cycle 3: main_g for 10 cycles, main_y 3, all red 2, side_g 6, side_y 3, all red 2, then main_g=1 again; walk never 1.
- ped_req pulse in main green: main_g 10, main_y 3, all red 2, walk=1 for 4 cycles with both reds high, all red 2, main_g; a ped_req during walk does not trigger a second walk.
- side_req and ped_req both pulsed in main green: side phase (g6/y3), RED_B 2 cycles, walk 4, RED_B 2 cycles, main_g; phase sequence 0,1,2,3,4,5,6,5,0.
- side_req rising 40 cycles into main green: main_y asserts exactly 1 cycle after the sampling edge.
- reset asserted mid-SIDE_G, between clock edges: side_g drops and main_r=side_r=1 immediately; phase=5; after release the sequence is a 2-cycle all-red then main_g, with no side phase since pending was cleared.
